// File: rtl/chan_pkg.sv
// chan_pkg: shared types, constants and helpers for the corrupting channel
package chan_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} chan_state_t;
  typedef enum logic [1:0] {MODE_NONE, MODE_B0, MODE_B1, MODE_BOTH} chan_mode_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {1'b0, m[1]} + {1'b0, m[0]};
  endfunction
endpackage

// File: rtl/channel_error_injector_if.sv
// channel_error_injector_if: symbol stream into and out of the corrupting channel
interface channel_error_injector_if;
  logic       enable_i;
  logic [1:0] d_in;
  logic       valid_o;
  logic [1:0] d_out;
  logic [1:0] err_mask_o;
  modport master(output enable_i, d_in, input valid_o, d_out, err_mask_o);
  modport slave(input enable_i, d_in, output valid_o, d_out, err_mask_o);
endinterface

// File: rtl/chan_lfsr.sv
// chan_lfsr: 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, steps when adv_i is high
module chan_lfsr
  import chan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  output logic [15:0] state_o
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_o <= LFSR_SEED;
    else if (adv_i) state_o <= {^(state_o & LFSR_TAPS), state_o[15:1]};
endmodule

// File: rtl/channel_error_injector.sv
// channel_error_injector: registered 2-bit channel that flips bits in periodic bursts
// Define CHAN_LFSR_EN to draw the mode-11 mask from a seeded LFSR instead of flipping both bits.
module channel_error_injector
  import chan_pkg::*;
#(
  parameter int N           = 5,
  parameter int BURST_LEN   = 2,
  parameter int STAT_WINDOW = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inj_en_i,
  input  logic [1:0]  mode_i,
  channel_error_injector_if.slave sym,
  output logic [31:0] word_ct_o,
  output logic [31:0] bad_bit_ct_o
);
  localparam int PERIOD = 2 ** N;
  localparam int PW = (N > 0) ? N : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [PW-1:0] PLAST = PW'(PERIOD - 1);
  localparam logic [BW-1:0] BLAST = BW'(BURST_LEN);
  chan_state_t   state;
  logic [PW-1:0] pcnt;
  logic [BW-1:0] bcnt, bnext;
  logic          start, corrupt;
  logic [1:0]    both_mask, mask;
  logic [32:0]   bad_sum;
`ifdef CHAN_LFSR_EN
  logic [15:0] lfsr;
  chan_lfsr u_lfsr (.clk(clk), .rst(rst), .adv_i(sym.enable_i), .state_o(lfsr));
  assign both_mask = (lfsr[1:0] == 2'b00) ? 2'b01 : lfsr[1:0];
`else
  assign both_mask = 2'b11;
`endif
  always_comb begin
    start   = (state == IDLE) && (pcnt == PLAST) && inj_en_i;
    corrupt = inj_en_i && ((state == BURST) || start);
    bnext   = (state == IDLE) ? BW'(1) : bcnt + BW'(1);
    mask    = !corrupt ? 2'b00 : (mode_i == MODE_BOTH) ? both_mask : mode_i;
    bad_sum = {1'b0, bad_bit_ct_o} + 33'(popcount2(mask));
  end
  // burst bookkeeping only moves on valid symbols; dropping inj_en_i abandons it at once
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state          <= IDLE;
      pcnt           <= '0;
      bcnt           <= '0;
      sym.valid_o    <= 1'b0;
      sym.d_out      <= 2'b00;
      sym.err_mask_o <= 2'b00;
      word_ct_o      <= '0;
      bad_bit_ct_o   <= '0;
    end else begin
      sym.valid_o <= sym.enable_i;
      if (!inj_en_i) begin
        state <= IDLE;
        bcnt  <= '0;
      end else if (sym.enable_i && corrupt) begin
        state <= (bnext == BLAST) ? IDLE : BURST;
        bcnt  <= (bnext == BLAST) ? '0 : bnext;
      end
      if (sym.enable_i) begin
        pcnt           <= (pcnt == PLAST) ? '0 : pcnt + PW'(1);
        sym.d_out      <= sym.d_in ^ mask;
        sym.err_mask_o <= mask;
        word_ct_o      <= (word_ct_o == CNT_MAX) ? CNT_MAX : word_ct_o + 32'd1;
        if (word_ct_o < 32'(STAT_WINDOW)) bad_bit_ct_o <= bad_sum[32] ? CNT_MAX : bad_sum[31:0];
      end
    end
endmodule
